// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage with PC, IF/ID register, stall, redirect and halt
//
// Purpose: owns the program counter, presents pc to instruction memory and
// captures the returned word into the IF/ID register for decode.
// Optional build macro: FETCH_HALT_DET_EN (instr_in == 16'hFFFF halts fetch).
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   stall         hold pc and IF/ID (decode hazard)
//   redirect      branch/jump taken, load redir_target
//   redir_target  new byte address (bit 0 ignored)
//   instr_in      instruction word from memory for current pc
//   pc            current fetch byte address
//   if_id_instr   registered instruction for decode
//   if_id_pc      registered link value (pc + PC_STEP) of that instruction
//   if_id_valid   IF/ID holds a real instruction
//   halted        fetch stopped
//   fetch_cnt     saturating count of valid IF/ID loads
module fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          PC_STEP    = 2,
  parameter int          PROG_WORDS = 16,
  parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redir_target,
  input  logic [15:0] instr_in,
  output logic [15:0] pc,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] fetch_cnt
);

  localparam logic [15:0] LAST_PC = 16'(2 * PROG_WORDS - 2);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state;

  logic [16:0] pc_inc;
  logic        end_of_prog;
  logic [15:0] tgt;
  logic        halt_op;

  // 17-bit sum so the end-of-program compare cannot be fooled by wrap.
  assign pc_inc      = {1'b0, pc} + 17'(PC_STEP);
  assign end_of_prog = pc_inc > {1'b0, LAST_PC};
  assign tgt         = {redir_target[15:1], 1'b0};

`ifdef FETCH_HALT_DET_EN
  assign halt_op = (instr_in == 16'hFFFF);
`else
  assign halt_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= 16'h0000;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_cnt   <= 16'h0000;
    end else if (redirect) begin
      // Redirect wins over stall and leaves HALT; the wrong-path slot becomes a bubble.
      pc          <= tgt;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      if (tgt > LAST_PC) begin
        state  <= HALT;
        halted <= 1'b1;
      end else begin
        state  <= FLUSH;
        halted <= 1'b0;
      end
    end else begin
      case (state)
        HALT: begin
          // First HALT edge replaces the last valid instruction with a bubble; later edges re-load the same bubble.
          if_id_instr <= NOP_INSTR;
          if_id_valid <= 1'b0;
          halted      <= 1'b1;
        end
        default: begin
          // FETCH and FLUSH behave identically; FLUSH only marks the post-redirect cycle.
          if (stall) begin
            state <= FETCH;
          end else begin
            if_id_instr <= instr_in;
            if_id_pc    <= pc_inc[15:0];
            if_id_valid <= 1'b1;
            if (fetch_cnt != 16'hFFFF) begin
              fetch_cnt <= fetch_cnt + 16'd1;
            end
            if (end_of_prog || halt_op) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state <= FETCH;
              pc    <= pc_inc[15:0];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a rule-level model
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redir_target;
  logic [15:0] instr_in;
  logic [15:0] pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] fetch_cnt;

  logic [15:0] mem [16];

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_pc;
  logic [15:0] m_instr;
  logic [15:0] m_ipc;
  logic        m_valid;
  logic        m_halted;
  int          m_cnt;

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .redirect     (redirect),
    .redir_target (redir_target),
    .instr_in     (instr_in),
    .pc           (pc),
    .if_id_instr  (if_id_instr),
    .if_id_pc     (if_id_pc),
    .if_id_valid  (if_id_valid),
    .halted       (halted),
    .fetch_cnt    (fetch_cnt)
  );

  always #5 clk = ~clk;

  // combinational instruction memory
  always_comb begin
    if (pc < 16'd32) instr_in = mem[pc[4:1]];
    else             instr_in = 16'hDEAD;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input int a);
    if (a < 32) return mem[a / 2];
    return 16'hDEAD;
  endfunction

  // One clock: apply inputs, advance the model by the spec rules, compare after the edge.
  task automatic step(input bit r, input bit s, input bit rd, input logic [15:0] t);
    logic [15:0] w;
    int          a;
    bit          stop;
    rst_n = ~r; stall = s; redirect = rd; redir_target = t;
    if (r) begin
      m_pc = 0; m_instr = 16'h0000; m_ipc = 16'h0000; m_valid = 1'b0; m_halted = 1'b0; m_cnt = 0;
    end else if (rd) begin
      a = int'(t) & 32'hFFFE;
      m_pc = a; m_instr = 16'h0000; m_valid = 1'b0;
      m_halted = (a > 30);
    end else if (m_halted) begin
      m_instr = 16'h0000; m_valid = 1'b0;
    end else if (!s) begin
      w = mem_word(m_pc);
      m_instr = w; m_ipc = 16'(m_pc + 2); m_valid = 1'b1;
      if (m_cnt < 65535) m_cnt++;
      stop = (m_pc + 2 > 30);
`ifdef FETCH_HALT_DET_EN
      if (w == 16'hFFFF) stop = 1'b1;
`endif
      if (stop) m_halted = 1'b1;
      else      m_pc = m_pc + 2;
    end
    @(posedge clk);
    #1;
    check("pc",          pc,                  16'(m_pc));
    check("if_id_instr", if_id_instr,         m_instr);
    check("if_id_pc",    if_id_pc,            m_ipc);
    check("if_id_valid", {15'd0, if_id_valid}, {15'd0, m_valid});
    check("halted",      {15'd0, halted},      {15'd0, m_halted});
    check("fetch_cnt",   fetch_cnt,           16'(m_cnt));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'(i);
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redir_target = 16'h0000;

    // reset and straight-line run to end of program
    step(1'b1, 1'b0, 1'b1, 16'h0008);
    check("reset_pc", pc, 16'h0000);
    check("reset_valid", {15'd0, if_id_valid}, 16'd0);
    run(15);
    check("pc_30", pc, 16'd30);
    check("instr_14", if_id_instr, 16'd14);
    run(1);
    check("halt_after_last", {15'd0, halted}, 16'd1);
    check("last_instr", if_id_instr, 16'd15);
    check("cnt_16", fetch_cnt, 16'd16);
    run(1);
    check("halt_bubble", {15'd0, if_id_valid}, 16'd0);
    run(2);

    // stall at pc=6
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    run(3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0000);
    check("stall_pc", pc, 16'd6);
    check("stall_instr", if_id_instr, 16'd2);
    check("stall_cnt", fetch_cnt, 16'd3);
    run(1);
    check("release_instr", if_id_instr, 16'd3);

    // redirect at pc=10, then redirect+stall
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    run(5);
    check("pre_redir_pc", pc, 16'd10);
    step(1'b0, 1'b0, 1'b1, 16'h0015);
    check("redir_pc", pc, 16'd20);
    check("redir_bubble", {15'd0, if_id_valid}, 16'd0);
    run(1);
    check("redir_instr", if_id_instr, 16'd10);
    step(1'b0, 1'b1, 1'b1, 16'h0015);
    check("redir_stall_pc", pc, 16'd20);
    run(1);
    check("redir_stall_instr", if_id_instr, 16'd10);

    // redirect out of range, stall in HALT, redirect back
    step(1'b0, 1'b0, 1'b1, 16'h0040);
    check("oor_halted", {15'd0, halted}, 16'd1);
    check("oor_pc", pc, 16'h0040);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 16'h0004);
    check("unhalt", {15'd0, halted}, 16'd0);
    run(1);
    check("unhalt_instr", if_id_instr, 16'd2);
    run(3);
    step(1'b1, 1'b1, 1'b1, 16'h0010);

    // HALT opcode at word 5
    mem[5] = 16'hFFFF;
    run(6);
`ifdef FETCH_HALT_DET_EN
    check("hdet_pc", pc, 16'd10);
    check("hdet_halted", {15'd0, halted}, 16'd1);
    check("hdet_cnt", fetch_cnt, 16'd6);
`else
    check("nohdet_pc", pc, 16'd12);
    check("nohdet_halted", {15'd0, halted}, 16'd0);
`endif
    check("ffff_instr", if_id_instr, 16'hFFFF);
    run(2);

    // randomized traffic
    for (int i = 0; i < 16; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 11) == 0,
           16'($urandom_range(0, 40)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the byte address into instruction memory.
- Captures the combinational instruction word returned by instruction memory into an IF/ID pipeline register.
- Handles decode-stage stalls, branch/jump redirects with one-bubble flush, and end-of-program halt.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset; must be even.
- PC_STEP, 2, byte increment per sequential fetch (16-bit instruction words).
- PROG_WORDS, 16, number of valid instruction words; fetch address range is 0 .. 2*PROG_WORDS-2.
- NOP_INSTR, 16'h0000, instruction word inserted into IF/ID on bubbles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- stall  input  1  hold PC and IF/ID contents (decode hazard)
- redirect  input  1  branch/jump taken; load redir_target
- redir_target  input  16  new byte address
- instr_in  input  16  instruction word from instruction memory for current pc
- pc  output  16  current fetch byte address to instruction memory
- if_id_instr  output  16  registered instruction for decode
- if_id_pc  output  16  registered pc + PC_STEP (link value) of that instruction
- if_id_valid  output  1  IF/ID holds a real instruction
- halted  output  1  fetch stopped at end of program
- fetch_cnt  output  16  count of instructions loaded valid into IF/ID, saturating

Behaviour:
- Single clock domain. rst_n is sampled only on the rising edge of clk.
- Reset (rst_n=0 at an edge), regardless of any other input:
  - pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_valid=0, halted=0, fetch_cnt=0.
  - FSM enters FETCH.
  - Reset mid-stall, mid-flush or in HALT behaves identically.
- pc is a register, driven directly (no combinational path from inputs).
- instr_in is sampled at the same edge that advances pc. The instruction at address A therefore appears on if_id_instr one cycle after pc=A.
- FSM states: FETCH, FLUSH, HALT.
- Priority at each edge: reset > redirect > stall > normal.
- FETCH, normal:
  - if_id_instr<=instr_in, if_id_pc<=pc+PC_STEP, if_id_valid<=1, fetch_cnt++.
  - If pc+PC_STEP > 2*PROG_WORDS-2: pc holds and next state is HALT. The last instruction is still loaded valid.
  - Otherwise pc<=pc+PC_STEP.
- FETCH, stall=1 (no redirect): pc, IF/ID and fetch_cnt all hold. State stays FETCH.
- redirect=1 in any non-reset state, including with stall=1:
  - pc<={redir_target[15:1],1'b0}; bit 0 is forced to 0.
  - IF/ID loaded with bubble: if_id_instr=NOP_INSTR, if_id_valid=0, if_id_pc holds.
  - halted<=0. Next state is FLUSH.
  - If the aligned target exceeds 2*PROG_WORDS-2: pc still loads it, but next state is HALT and halted<=1.
- FLUSH (one cycle): behaves exactly as FETCH, so the instruction at the target loads valid. Stall and redirect are honoured with the same priority. Returns to FETCH.
- HALT:
  - halted=1, pc frozen.
  - IF/ID loads a bubble on the first HALT edge, then holds the bubble.
  - stall is ignored.
  - Exit only via reset or redirect.
- halted asserts on the edge entering HALT.
- Arithmetic is 16-bit unsigned. pc+PC_STEP wrap at 16'hFFFE cannot be reached, because the end-of-program check precedes the increment.
- fetch_cnt saturates at 16'hFFFF. It never increments on stall, bubble or HALT.

Optional Feature:
Macro FETCH_HALT_DET_EN.
- Defined:
  - In FETCH/FLUSH with no redirect or stall, if instr_in==16'hFFFF (HALT opcode), the instruction is loaded valid into IF/ID, fetch_cnt increments, pc holds, and the next state is HALT.
  - Subsequent behaviour is identical to end-of-program HALT.
- Not defined: 16'hFFFF is treated as an ordinary instruction and fetch continues sequentially.

Test Plan:
- Reset then run, PROG_WORDS=16 with mem[i]=i:
  - pc steps 0,2,4,...,30.
  - if_id_instr=0,1,2,... one cycle behind pc, if_id_pc=2,4,....
  - After mem[15] loads: halted=1, if_id_valid=0 next cycle, fetch_cnt=16.
- stall=1 for 3 cycles at pc=6: pc stays 6, if_id_instr stays 2, fetch_cnt unchanged. Release: if_id_instr=3 next edge.
- redirect=1, redir_target=16'h0015 at pc=10:
  - pc=20, one bubble (if_id_valid=0, if_id_instr=0).
  - Next edge: if_id_instr=10, valid=1.
- redirect and stall both high at the same edge: redirect wins, same result as above. redirect=1 to 16'h0040: halted=1, no valid fetch.
- In HALT: stall toggling causes no change. redirect to 16'h0004 clears halted, and mem[2] loads after one bubble. rst_n=0 mid-run: all outputs at reset values next edge.
- FETCH_HALT_DET_EN defined, mem[5]=16'hFFFF: pc freezes at 10, if_id_instr=FFFF valid, halted=1, fetch_cnt=6. Macro undefined: fetch continues to pc=12.
